ce_pulse_gen: RTL

- Programmable clock-enable pulse generator: the producer side of the ce input consumed by the team's cascadable counters.
- Emits single-cycle `ce_out` pulses every `period` clocks, either continuously or as a burst of exactly `count` pulses.
- Sits between control logic and counter chains so counters can be stepped at a divided rate or a fixed number of times.

---
 rtl/ce_gen_pkg.sv | 12 +
 rtl/ce_div_core.sv | 44 ++++
 rtl/ce_pulse_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/ce_gen_pkg.sv
// Shared types and constants for the clock-enable pulse generator.
package ce_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/ce_div_core.sv
// Reloadable PW-bit down-divider: emits a registered one-cycle tick each time
// the count has reached zero while enabled, then reloads.
module ce_div_core #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          load,
  input  logic          en,
  input  logic [PW-1:0] reload,
  output logic          tick,
  output logic          zero
);

  logic [PW-1:0] cnt;
  logic [PW-1:0] reload_q;

  // Lets the owner see, before the edge, whether this edge will emit a tick.
  assign zero = (cnt == '0);

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt      <= '0;
      reload_q <= '0;
      tick     <= 1'b0;
    end else if (load) begin
      cnt      <= reload;
      reload_q <= reload;
      tick     <= 1'b0;
    end else if (en) begin
      if (zero) begin
        tick <= 1'b1;
        cnt  <= reload_q;
      end else begin
        tick <= 1'b0;
        cnt  <= cnt - 1'b1;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ce_pulse_gen.sv
// Programmable clock-enable pulse generator: continuous or fixed-length burst
// of single-cycle ce_out pulses spaced 'period' clocks apart.
module ce_pulse_gen
  import ce_gen_pkg::*;
#(
  parameter int PW = 8,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [PW-1:0] period,
  input  logic [NW-1:0] count,
  output logic          ce_out,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic          mode_q;
  logic [NW-1:0] remaining;
  logic          empty_pend;

  logic          accept;
  logic          empty_burst;
  logic          load;
  logic          run_en;
  logic          div_zero;
  logic          fire;
  logic [PW-1:0] reload_val;

  assign accept      = (state == IDLE) && start && !stop;
  assign empty_burst = (mode == MODE_BURST) && (count == '0);
  assign load        = accept && !empty_burst;
  assign run_en      = (state == RUN) && !stop;
  assign fire        = run_en && div_zero;
  // A period of 0 behaves as 1, so the reload value never underflows.
  assign reload_val  = (period == '0) ? '0 : period - 1'b1;

  ce_div_core #(.PW(PW)) u_div (
    .clk    (clk),
    .clr_n  (clr_n),
    .load   (load),
    .en     (run_en),
    .reload (reload_val),
    .tick   (ce_out),
    .zero   (div_zero)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      mode_q     <= MODE_CONT;
      remaining  <= '0;
      empty_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // An empty burst completes one edge after it is accepted.
          done       <= empty_pend;
          empty_pend <= 1'b0;
          if (accept) begin
            if (empty_burst) begin
              empty_pend <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              mode_q    <= mode;
              remaining <= count;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (fire && (mode_q == MODE_BURST)) begin
            remaining <= remaining - 1'b1;
            if (remaining == NW'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
